// File: rtl/shake256_squeeze_reader.sv
// shake256_squeeze_reader
//   Consumer side of the SHAKE256 squeeze interface. Each rising edge of
//   `squeezed` marks a fresh rate block on `hash`; the block is captured and
//   serialized MSB-first into a WORD_W-bit valid/ready stream until the
//   requested number of output bits has been delivered, then `done` pulses.
//
//   Buffering is one active shift register plus one pending block register.
//   A block arriving while both are occupied is dropped and sets the sticky
//   `overflow` flag (cleared by the next accepted start).
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   one-cycle pulse arming a new read (only honoured in IDLE)
//   out_bits  in   requested output length in bits, sampled with start
//   squeezed  in   core flag, rising edge = new block valid on hash
//   hash      in   rate block, first output bits in [RATE_BITS-1 -: WORD_W]
//   m_data    out  output word (registered)
//   m_valid   out  output word valid (registered)
//   m_ready   in   downstream accept
//   m_last    out  final word of the request
//   busy      out  high from accepted start through the done cycle
//   done      out  one-cycle pulse after the last word is accepted
//   overflow  out  sticky block-dropped flag
//
// Build option
//   SHAKE_SQZ_BYTESWAP_EN : byte-reverse each output word (Keccak
//   little-endian lane order); the partial-word zero mask is applied after
//   the swap. Undefined: the MSB-first slice of hash is emitted unchanged.
//
// States
//   state       | meaning
//   ST_IDLE     | waiting for start, blocks ignored
//   ST_WAIT_BLK | request armed, active buffer empty
//   ST_DRAIN    | streaming words out of the active buffer
//   ST_DONE     | done pulse, buffers discarded, blocks ignored

module shake256_squeeze_reader #(
    parameter int RATE_BITS = 1088,
    parameter int WORD_W    = 64,
    parameter int OUT_LEN_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OUT_LEN_W-1:0] out_bits,
    input  logic                 squeezed,
    input  logic [RATE_BITS-1:0] hash,
    output logic [WORD_W-1:0]    m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int K      = RATE_BITS / WORD_W;
    localparam int IDX_W  = $clog2(K + 1);
    localparam int TAIL_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BLK,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state_q, state_nxt;
    logic [RATE_BITS-1:0]   act_q, act_nxt;
    logic                   act_full_q, act_full_nxt;
    logic [RATE_BITS-1:0]   pend_q, pend_nxt;
    logic                   pend_full_q, pend_full_nxt;
    logic [IDX_W-1:0]       blk_idx_q, blk_idx_nxt;
    logic [OUT_LEN_W-1:0]   rem_q, rem_nxt;
    logic [TAIL_W-1:0]      tail_q, tail_nxt;
    logic                   ovf_q, ovf_nxt;
    logic                   sq_d;

    logic [WORD_W-1:0]      m_data_q, m_data_nxt;
    logic                   m_valid_q, m_last_q, busy_q, done_q;

    logic                   new_blk;
    logic                   blk_live;
    logic                   hs;
    logic                   emptying;
    logic                   last_hs;
    logic                   act_vacant;
    logic [OUT_LEN_W-1:0]   words_req;

    logic [WORD_W-1:0]      top_word;
    logic [WORD_W-1:0]      swapped;
    logic [WORD_W-1:0]      keep_mask;

    assign new_blk  = squeezed & ~sq_d;
    assign blk_live = new_blk & ((state_q == ST_WAIT_BLK) | (state_q == ST_DRAIN));

    // m_valid_q is high exactly while in DRAIN, so this is the handshake.
    assign hs       = m_valid_q & m_ready;
    assign emptying = hs & (blk_idx_q == IDX_W'(K - 1));
    assign last_hs  = hs & (rem_q == OUT_LEN_W'(1));

    // ceil(out_bits / WORD_W) without widening: whole words plus one for any tail.
    assign words_req = (out_bits >> TAIL_W)
                     + {{(OUT_LEN_W-1){1'b0}}, |out_bits[TAIL_W-1:0]};

    always_comb begin
        state_nxt     = state_q;
        act_nxt       = act_q;
        act_full_nxt  = act_full_q;
        pend_nxt      = pend_q;
        pend_full_nxt = pend_full_q;
        blk_idx_nxt   = blk_idx_q;
        rem_nxt       = rem_q;
        tail_nxt      = tail_q;
        ovf_nxt       = ovf_q;
        act_vacant    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_nxt       = words_req;
                    tail_nxt      = out_bits[TAIL_W-1:0];
                    ovf_nxt       = 1'b0;
                    blk_idx_nxt   = '0;
                    act_full_nxt  = 1'b0;
                    pend_full_nxt = 1'b0;
                    state_nxt     = (words_req == '0) ? ST_DONE : ST_WAIT_BLK;
                end
            end

            ST_WAIT_BLK, ST_DRAIN: begin
                if (hs) begin
                    act_nxt     = {act_q[RATE_BITS-WORD_W-1:0], {WORD_W{1'b0}}};
                    blk_idx_nxt = blk_idx_q + IDX_W'(1);
                    rem_nxt     = rem_q - OUT_LEN_W'(1);
                end

                // The active buffer counts as free in the cycle its last word
                // leaves, so a refill lands without a bubble on m_valid.
                act_vacant = ~act_full_q | emptying;

                if (act_vacant) begin
                    if (pend_full_q) begin
                        act_nxt       = pend_q;
                        act_full_nxt  = 1'b1;
                        blk_idx_nxt   = '0;
                        pend_full_nxt = 1'b0;
                        if (blk_live) begin
                            pend_nxt      = hash;
                            pend_full_nxt = 1'b1;
                        end
                    end else if (blk_live) begin
                        act_nxt      = hash;
                        act_full_nxt = 1'b1;
                        blk_idx_nxt  = '0;
                    end else begin
                        act_full_nxt = 1'b0;
                        blk_idx_nxt  = '0;
                    end
                end else if (blk_live) begin
                    if (!pend_full_q) begin
                        pend_nxt      = hash;
                        pend_full_nxt = 1'b1;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end

                if (last_hs) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = act_full_nxt ? ST_DRAIN : ST_WAIT_BLK;
                end
            end

            ST_DONE: begin
                act_full_nxt  = 1'b0;
                pend_full_nxt = 1'b0;
                blk_idx_nxt   = '0;
                state_nxt     = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output word formatting from the next-cycle buffer contents, so m_data
    // is a flop and tracks the shift without an extra cycle.
    always_comb begin
        top_word = act_nxt[RATE_BITS-1 -: WORD_W];
`ifdef SHAKE_SQZ_BYTESWAP_EN
        swapped = '0;
        for (int b = 0; b < WORD_W / 8; b++) begin
            swapped[8*b +: 8] = top_word[WORD_W-8-8*b +: 8];
        end
`else
        swapped = top_word;
`endif
        keep_mask = '1;
        if ((rem_nxt == OUT_LEN_W'(1)) && (tail_nxt != '0)) begin
            for (int i = 0; i < WORD_W; i++) begin
                keep_mask[i] = (i + int'(tail_nxt) >= WORD_W);
            end
        end
        m_data_nxt = swapped & keep_mask;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            act_q       <= '0;
            act_full_q  <= 1'b0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            blk_idx_q   <= '0;
            rem_q       <= '0;
            tail_q      <= '0;
            ovf_q       <= 1'b0;
            sq_d        <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            act_q       <= act_nxt;
            act_full_q  <= act_full_nxt;
            pend_q      <= pend_nxt;
            pend_full_q <= pend_full_nxt;
            blk_idx_q   <= blk_idx_nxt;
            rem_q       <= rem_nxt;
            tail_q      <= tail_nxt;
            ovf_q       <= ovf_nxt;
            sq_d        <= squeezed;
            m_data_q    <= m_data_nxt;
            m_valid_q   <= (state_nxt == ST_DRAIN);
            m_last_q    <= (state_nxt == ST_DRAIN) && (rem_nxt == OUT_LEN_W'(1));
            busy_q      <= (state_nxt != ST_IDLE);
            done_q      <= (state_nxt == ST_DONE);
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule
